// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator.
// A prescaler divides the clock into ticks. A tick counter divides ticks
// into frames. Each frame opens with a pulse of BASE_TICKS+active_width ticks.
// Width commands are clamped and held as pending. They take effect only at
// a frame start, so the pulse width never changes in the middle of a frame.
module servo_pwm_gen #(
   parameter int TICK_DIV     = 1000,
   parameter int PERIOD_TICKS = 1000,
   parameter int BASE_TICKS   = 25,
   parameter int MAX_CYCLES   = 100
) (
   input  logic       in_Clk,
   input  logic       in_Rst,
   input  logic       in_Enable,
   input  logic       in_Valid,
   input  logic [9:0] in_Cycles,
   output logic       out_Pwm,
   output logic       out_Ack,
   output logic       out_FrameStart,
   output logic       out_Busy
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
   logic [9:0]    active_width_reg;
   logic [9:0]    pending_reg;
   logic          pending_flag_reg;
   logic          pwm_reg, ack_reg, frame_start_reg, busy_reg;

   logic          tick;
   logic          pulse_end;
   logic          frame_end;
   logic          new_frame;
   logic [9:0]    clamped_cycles;
   logic [31:0]   pulse_last_tick;

   // Tick/frame decode, next-state logic and counter updates
   always_comb begin
      tick            = (state_reg != ST_IDLE) && (presc_reg == PW'(TICK_DIV - 1));
      pulse_last_tick = 32'(BASE_TICKS) + 32'(active_width_reg) - 32'd1;
      pulse_end       = tick && (32'(tick_cnt_reg) == pulse_last_tick);
      frame_end       = tick && (tick_cnt_reg == TW'(PERIOD_TICKS - 1));
      clamped_cycles  = (in_Cycles > 10'(MAX_CYCLES)) ? 10'(MAX_CYCLES) : in_Cycles;

      state_next = state_reg;
      new_frame  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (in_Enable) begin
               state_next = ST_PULSE;
               new_frame  = 1'b1;
            end
         end
         ST_PULSE: begin
            // Enable is ignored here: a started pulse always completes
            if (pulse_end) state_next = ST_GAP;
         end
         ST_GAP: begin
            if (frame_end) begin
               if (in_Enable) begin
                  state_next = ST_PULSE;
                  new_frame  = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Counters rest at zero in IDLE, so the first PULSE clock is position 0
      if (state_reg == ST_IDLE) begin
         presc_next    = '0;
         tick_cnt_next = '0;
      end else if (tick) begin
         presc_next    = '0;
         tick_cnt_next = frame_end ? '0 : tick_cnt_reg + TW'(1);
      end else begin
         presc_next    = presc_reg + PW'(1);
         tick_cnt_next = tick_cnt_reg;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         state_reg       <= ST_IDLE;
         presc_reg       <= '0;
         tick_cnt_reg    <= '0;
         pwm_reg         <= 1'b0;
         busy_reg        <= 1'b0;
         frame_start_reg <= 1'b0;
         ack_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         presc_reg       <= presc_next;
         tick_cnt_reg    <= tick_cnt_next;
         pwm_reg         <= (state_next == ST_PULSE);
         busy_reg        <= (state_next != ST_IDLE);
         frame_start_reg <= new_frame;
         ack_reg         <= new_frame && pending_flag_reg;
      end
   end

   // Command capture: the last strobe wins and is promoted only at a frame start.
   // A strobe on the promoting edge refills pending for the following frame.
   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         active_width_reg <= '0;
         pending_reg      <= '0;
         pending_flag_reg <= 1'b0;
      end else begin
         if (new_frame && pending_flag_reg) active_width_reg <= pending_reg;
         if (in_Valid) begin
            pending_reg      <= clamped_cycles;
            pending_flag_reg <= 1'b1;
         end else if (new_frame) begin
            pending_flag_reg <= 1'b0;
         end
      end
   end

   assign out_Pwm        = pwm_reg;
   assign out_Ack        = ack_reg;
   assign out_FrameStart = frame_start_reg;
   assign out_Busy       = busy_reg;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with small parameters.
// A frame-level reference model predicts every output on every clock.
// A width table and directed sequences cover the corner cases.
module tb_servo_pwm_gen;

   localparam int TD        = 2;
   localparam int PT        = 20;
   localparam int BT        = 2;
   localparam int MC        = 10;
   localparam int FRAME_CLK = PT * TD;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       en     = 1'b0;
   logic       valid  = 1'b0;
   logic [9:0] cycles = '0;
   logic       out_Pwm, out_Ack, out_FrameStart, out_Busy;

   int n_cmp  = 0;
   int n_fail = 0;

   servo_pwm_gen #(
      .TICK_DIV    (TD),
      .PERIOD_TICKS(PT),
      .BASE_TICKS  (BT),
      .MAX_CYCLES  (MC)
   ) dut (
      .in_Clk        (clk),
      .in_Rst        (rst),
      .in_Enable     (en),
      .in_Valid      (valid),
      .in_Cycles     (cycles),
      .out_Pwm       (out_Pwm),
      .out_Ack       (out_Ack),
      .out_FrameStart(out_FrameStart),
      .out_Busy      (out_Busy)
   );

   always #5 clk = ~clk;

   // Reference model: position within the frame in clocks, plus width bookkeeping
   typedef struct packed {
      logic run;
      int   pos;
      int   aw;
      int   pend;
      logic pflag;
      logic pwm;
      logic ack;
      logic fs;
      logic busy;
   } mstate_t;

   function automatic mstate_t model_step(mstate_t s, logic e, logic v, logic [9:0] c);
      mstate_t n = s;
      bit start = 1'b0;
      n.ack = 1'b0;
      n.fs  = 1'b0;
      if (!s.run) begin
         if (e) start = 1'b1;
      end else begin
         n.pos = s.pos + 1;
         if (n.pos == FRAME_CLK) begin
            if (e) start = 1'b1;
            else begin
               n.run = 1'b0;
               n.pos = 0;
            end
         end
      end
      if (start) begin
         n.run = 1'b1;
         n.pos = 0;
         n.fs  = 1'b1;
         if (s.pflag) begin
            n.aw    = s.pend;
            n.pflag = 1'b0;
            n.ack   = 1'b1;
         end
      end
      if (v) begin
         n.pend  = (int'(c) > MC) ? MC : int'(c);
         n.pflag = 1'b1;
      end
      n.pwm  = n.run && (n.pos < (BT + n.aw) * TD);
      n.busy = n.run;
      return n;
   endfunction

   mstate_t m = '0;

   // Model tracks the DUT clock and asynchronous reset
   always @(posedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= model_step(m, en, valid, cycles);
   end

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Advance one clock and compare all outputs with the model
   task automatic cyc();
      logic [3:0] act, req;
      @(negedge clk);
      act = {out_Pwm, out_Ack, out_FrameStart, out_Busy};
      req = {m.pwm, m.ack, m.fs, m.busy};
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL model_cmp: actual pwm/ack/fs/busy=%b required=%b (t=%0t)", act, req, $time);
      end
   endtask

   task automatic wait_fs();
      int k = 0;
      while (!out_FrameStart && k < 200) begin
         cyc();
         k++;
      end
      if (!out_FrameStart) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_frame_start: actual=timeout required=frame start within 200 clocks");
      end
   endtask

   // Starting in a frame-start clock, measure one frame: high clocks, length, initial ack
   task automatic measure_frame(input bit do_v, input logic [9:0] cv, input int drop_at,
                                output int high, output int len, output bit ack0);
      ack0 = out_Ack;
      high = 0;
      len  = 0;
      if (do_v) begin
         valid  = 1'b1;
         cycles = cv;
      end
      do begin
         if (out_Pwm) high++;
         len++;
         if (len == drop_at) en = 1'b0;
         cyc();
         valid = 1'b0;
      end while (!out_FrameStart && out_Busy && len < 200);
   endtask

   typedef struct {
      logic [9:0] cyc_in;
      int         exp_high;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int  high, len, quiet;
      bit  ack0;

      vecs[0] = '{10'd5,    14};
      vecs[1] = '{10'd700,  24};
      vecs[2] = '{10'd0,     4};
      vecs[3] = '{10'd10,   24};
      vecs[4] = '{10'd11,   24};
      vecs[5] = '{10'd1023, 24};
      vecs[6] = '{10'd3,    10};
      vecs[7] = '{10'd5,    14};

      // Reset state
      #1 rst = 1'b1;
      cyc();
      cyc();
      check("reset_pwm",  int'(out_Pwm), 0);
      check("reset_ack",  int'(out_Ack), 0);
      check("reset_fs",   int'(out_FrameStart), 0);
      check("reset_busy", int'(out_Busy), 0);
      $display("reset: outputs pwm=%b ack=%b fs=%b busy=%b", out_Pwm, out_Ack, out_FrameStart, out_Busy);

      // Default frame with no command
      rst = 1'b0;
      en  = 1'b1;
      cyc();
      check("first_fs_after_idle", int'(out_FrameStart), 1);
      wait_fs();
      measure_frame(1'b0, '0, -1, high, len, ack0);
      check("default_high", high, 4);
      check("default_len", len, FRAME_CLK);
      check("default_ack", int'(ack0), 0);
      $display("default frame: high=%0d len=%0d ack=%0d", high, len, ack0);

      // Width table: command during GAP, takes effect next frame
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 30; k++) cyc();
         valid  = 1'b1;
         cycles = vecs[i].cyc_in;
         cyc();
         valid = 1'b0;
         wait_fs();
         measure_frame(1'b0, '0, -1, high, len, ack0);
         check("table_high", high, vecs[i].exp_high);
         check("table_ack", int'(ack0), 1);
         check("table_len", len, FRAME_CLK);
         $display("vector %0d: cycles=%0d high=%0d (want %0d) ack=%0d",
                  i, vecs[i].cyc_in, high, vecs[i].exp_high, ack0);
      end

      // Command in the frame-start clock while active width is 5
      measure_frame(1'b1, 10'd3, -1, high, len, ack0);
      check("fs_cmd_this_high", high, 14);
      check("fs_cmd_this_ack", int'(ack0), 0);
      measure_frame(1'b0, '0, -1, high, len, ack0);
      check("fs_cmd_next_high", high, 10);
      check("fs_cmd_next_ack", int'(ack0), 1);
      $display("frame-start command: next frame high=%0d ack=%0d", high, ack0);

      // Enable dropped mid-pulse: pulse and frame complete, then idle
      measure_frame(1'b0, '0, 2, high, len, ack0);
      check("drop_high", high, 10);
      check("drop_len", len, FRAME_CLK);
      check("drop_busy_after", int'(out_Busy), 0);
      quiet = 0;
      for (int k = 0; k < 10; k++) begin
         if (out_Pwm || out_Busy || out_FrameStart) quiet++;
         cyc();
      end
      check("drop_stays_idle", quiet, 0);
      $display("enable drop: high=%0d len=%0d then idle", high, len);

      // Reset asserted mid-pulse clears outputs without a clock edge
      en = 1'b1;
      cyc();
      wait_fs();
      cyc();
      cyc();
      check("pre_reset_pwm", int'(out_Pwm), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pwm",  int'(out_Pwm), 0);
      check("async_rst_busy", int'(out_Busy), 0);
      check("async_rst_ack",  int'(out_Ack), 0);
      check("async_rst_fs",   int'(out_FrameStart), 0);
      cyc();
      cyc();
      rst = 1'b0;
      en  = 1'b0;
      quiet = 0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (out_Busy || out_Pwm) quiet++;
      end
      check("post_reset_idle", quiet, 0);
      en = 1'b1;
      cyc();
      check("post_reset_fs", int'(out_FrameStart), 1);
      measure_frame(1'b0, '0, -1, high, len, ack0);
      check("post_reset_high", high, 4);
      check("post_reset_ack", int'(ack0), 0);
      $display("mid-pulse reset: restart high=%0d ack=%0d", high, ack0);

      // Random stimulus against the model
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 299) == 0) en = ~en;
         else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
         valid = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 1) == 0) cycles = 10'($urandom_range(0, 15));
         else                           cycles = 10'($urandom_range(0, 1023));
         rst = ($urandom_range(0, 1499) == 0);
         cyc();
      end
      valid = 1'b0;
      rst   = 1'b0;
      $display("random phase: 4000 clocks applied");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
